// File: rtl/mem_arbiter_if.sv
// Bus between the three requesters, the arbiter and the single-port RAM.
// The slave view belongs to the arbiter. The master view is the combined
// requester/RAM side.
interface mem_arbiter_if;
  // Requester side: data (port 0), fetch (port 1), loader (port 2)
  logic        d_req,   f_req,   l_req;
  logic        d_we,             l_we;
  logic [31:0] d_addr,  f_addr,  l_addr;
  logic [31:0] d_wdata,          l_wdata;
  logic        d_gnt,   f_gnt,   l_gnt;
  logic        d_ack,   f_ack,   l_ack;
  logic [31:0] d_rdata, f_rdata, l_rdata;
  logic        busy;

  // RAM side
  logic [29:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  modport slave (
    input  d_req, f_req, l_req, d_we, l_we,
    input  d_addr, f_addr, l_addr, d_wdata, l_wdata,
    input  ram_q,
    output d_gnt, f_gnt, l_gnt, d_ack, f_ack, l_ack,
    output d_rdata, f_rdata, l_rdata, busy,
    output ram_address, ram_data, ram_wren
  );

  modport master (
    output d_req, f_req, l_req, d_we, l_we,
    output d_addr, f_addr, l_addr, d_wdata, l_wdata,
    output ram_q,
    input  d_gnt, f_gnt, l_gnt, d_ack, f_ack, l_ack,
    input  d_rdata, f_rdata, l_rdata, busy,
    input  ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPU data, CPU fetch and loader/debug ports.
// Every access goes IDLE -> ACCESS -> RESP, so one access completes every three
// cycles. Fixed priority d > f > l is used, except that a fetch or loader port
// that has watched STARVE_LIMIT other grants goes first.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {PORT_D, PORT_F, PORT_L} port_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  port_t      win, owner;
  logic       any_req;
  logic       f_starved, l_starved;
  logic       lat_we;
  logic [3:0] f_wait, l_wait;

  // The low two address bits are byte offsets. The RAM is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.d_addr[1:0], bus.f_addr[1:0], bus.l_addr[1:0]};

  // Saturating wait count. It is cleared when the port is not asking or
  // when it wins.
  function automatic logic [3:0] next_wait(logic [3:0] cnt, logic req, logic won);
    if (!req || won)       return 4'd0;
    else if (cnt == LIMIT) return cnt;
    else                   return cnt + 4'd1;
  endfunction

  assign f_starved = (f_wait == LIMIT);
  assign l_starved = (l_wait == LIMIT);
  assign any_req   = bus.d_req | bus.f_req | bus.l_req;

  // Status and RAM write strobe decode directly from the state register
  assign bus.busy     = (state != IDLE);
  assign bus.ram_wren = (state == ACCESS) && lat_we;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Winner selection and next-state logic
  always_comb begin
    // NOTE: every signal gets a default value before the branches. Without this, a missed path would infer a latch.
    state_next = state;
    win        = PORT_D;

    if      (bus.f_req && f_starved) win = PORT_F;
    else if (bus.l_req && l_starved) win = PORT_L;
    else if (bus.d_req)              win = PORT_D;
    else if (bus.f_req)              win = PORT_F;
    else if (bus.l_req)              win = PORT_L;

    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, wait counters, grant/ack pulses and read-data return
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments only. All flops then update together at the clock edge.
    if (reset) begin
      owner           <= PORT_D;
      lat_we          <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_data    <= '0;
      f_wait          <= '0;
      l_wait          <= '0;
      bus.d_gnt       <= 1'b0;
      bus.f_gnt       <= 1'b0;
      bus.l_gnt       <= 1'b0;
      bus.d_ack       <= 1'b0;
      bus.f_ack       <= 1'b0;
      bus.l_ack       <= 1'b0;
      bus.d_rdata     <= '0;
      bus.f_rdata     <= '0;
      bus.l_rdata     <= '0;
    end else begin
      bus.d_gnt <= 1'b0;
      bus.f_gnt <= 1'b0;
      bus.l_gnt <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.f_ack <= 1'b0;
      bus.l_ack <= 1'b0;

      case (state)
        IDLE: begin
          f_wait <= next_wait(f_wait, bus.f_req, win == PORT_F);
          l_wait <= next_wait(l_wait, bus.l_req, win == PORT_L);
          if (any_req) begin
            owner <= win;
            case (win)
              PORT_F: begin
                bus.f_gnt       <= 1'b1;
                lat_we          <= 1'b0;
                bus.ram_address <= bus.f_addr[31:2];
              end
              PORT_L: begin
                bus.l_gnt       <= 1'b1;
                lat_we          <= bus.l_we;
                bus.ram_address <= bus.l_addr[31:2];
                bus.ram_data    <= bus.l_wdata;
              end
              default: begin
                bus.d_gnt       <= 1'b1;
                lat_we          <= bus.d_we;
                bus.ram_address <= bus.d_addr[31:2];
                bus.ram_data    <= bus.d_wdata;
              end
            endcase
          end
        end
        RESP: begin
          case (owner)
            PORT_F: begin
              bus.f_ack <= 1'b1;
              if (!lat_we) bus.f_rdata <= bus.ram_q;
            end
            PORT_L: begin
              bus.l_ack <= 1'b1;
              if (!lat_we) bus.l_rdata <= bus.ram_q;
            end
            default: begin
              bus.d_ack <= 1'b1;
              if (!lat_we) bus.d_rdata <= bus.ram_q;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
